// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and constants for the fetch controller:
//                FSM state encoding, fetch control word bit positions and
//                the named control words driven by the FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_ERR   = 3'd5
    } fetch_state_e;

    localparam int unsigned CW_W = 6;

    // Bit positions inside the fetch control word
    localparam int unsigned CW_PC_EN      = 5;
    localparam int unsigned CW_PC_SRC_RED = 4;
    localparam int unsigned CW_IMEM_RD_EN = 3;
    localparam int unsigned CW_IR_FLUSH   = 2;
    localparam int unsigned CW_IR_WR_EN   = 1;
    localparam int unsigned CW_STALL_HOLD = 0;

    localparam logic [CW_W-1:0] CW_ONE   = 6'b000001;

    localparam logic [CW_W-1:0] CW_NOP   = 6'b000000;
    localparam logic [CW_W-1:0] CW_REQ   = CW_ONE << CW_IMEM_RD_EN;
    localparam logic [CW_W-1:0] CW_CAPT  = (CW_ONE << CW_PC_EN)
                                         | (CW_ONE << CW_IMEM_RD_EN)
                                         | (CW_ONE << CW_IR_WR_EN);
    localparam logic [CW_W-1:0] CW_REDIR = (CW_ONE << CW_PC_EN)
                                         | (CW_ONE << CW_PC_SRC_RED)
                                         | (CW_ONE << CW_IR_FLUSH);
    localparam logic [CW_W-1:0] CW_HOLD  = CW_ONE << CW_STALL_HOLD;

endpackage
`default_nettype wire

// File: rtl/fetch_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_wait_timer
//  Description : Response wait counter. Cleared when a request is granted,
//                counts every cycle a response is outstanding and flags
//                expiry in the cycle the count would reach MAX_WAIT.
//  Revision    : 1.0 - initial release
//  Ports       : clk      - clock, rising edge
//                rst      - synchronous active-high reset
//                i_clr    - clear the count (wins over i_inc)
//                i_inc    - count this cycle
//                o_expire - this counting cycle is the MAX_WAIT-th one
// ============================================================================
module fetch_wait_timer #(
    parameter int unsigned MAX_WAIT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expire
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_inc) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count value is the number of cycles already waited, so the cycle that
    // sees MAX_WAIT-1 is the last one allowed.
    assign o_expire = i_inc && !i_clr && (cnt_q == CNT_W'(MAX_WAIT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl_fsm
//  Description : Instruction fetch controller. Owns the PC, issues one
//                outstanding instruction-memory request at a time, fills the
//                IF/ID slot, handles stall, redirect and response timeout,
//                and decodes the 6-bit fetch control word.
//  Revision    : 1.0 - initial release
//  Ports       : Clk, Rst        - clock / synchronous active-high reset
//                En, Stall       - fetch enable / downstream not accepting
//                Redirect(Pc)    - one-cycle redirect pulse and target
//                IMemReq/Addr/Gnt- request handshake to instruction memory
//                IMemRValid/RData- instruction memory response
//                Instr/InstrPc/InstrValid - IF/ID slot
//                CtrlWrd         - fetch control word
//                Busy, Timeout   - status (Timeout is sticky until Rst)
// ============================================================================
module fetch_ctrl_fsm
    import fetch_pkg::*;
#(
    parameter int unsigned           XLEN     = 32,
    parameter int unsigned           ILEN     = 32,
    parameter logic [XLEN-1:0]       RESET_PC = '0,
    parameter int unsigned           PC_INC   = 4,
    parameter int unsigned           MAX_WAIT = 64
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            En,
    input  logic            Stall,
    input  logic            Redirect,
    input  logic [XLEN-1:0] RedirectPc,
    output logic            IMemReq,
    output logic [XLEN-1:0] IMemAddr,
    input  logic            IMemGnt,
    input  logic            IMemRValid,
    input  logic [ILEN-1:0] IMemRData,
    output logic [ILEN-1:0] Instr,
    output logic [XLEN-1:0] InstrPc,
    output logic            InstrValid,
    output logic [CW_W-1:0] CtrlWrd,
    output logic            Busy,
    output logic            Timeout
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;
    logic [ILEN-1:0] instr_q, instr_d;
    logic            instr_valid_q, instr_valid_d;
    logic            timeout_q, timeout_d;

    logic            req;
    logic            consume;
    logic            redir;
    logic            tmr_clr;
    logic            tmr_inc;
    logic            tmr_expire;
    logic [CW_W-1:0] cw;

    fetch_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk      (Clk),
        .rst      (Rst),
        .i_clr    (tmr_clr),
        .i_inc    (tmr_inc),
        .o_expire (tmr_expire)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        timeout_d     = timeout_q;
        req           = 1'b0;
        tmr_clr       = 1'b0;
        tmr_inc       = 1'b0;
        cw            = CW_NOP;

        consume = instr_valid_q && !Stall;
        // ERR is absorbing, so a redirect there has no effect at all.
        redir   = Redirect && (state_q != ST_ERR);

        if (consume) begin
            instr_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (En) begin
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                cw  = CW_REQ;
                // Only ask when the slot will have room for the result.
                req = En && (!instr_valid_q || !Stall);
                if (req && IMemGnt) begin
                    // A granted request is outstanding even if redirected:
                    // its response still has to be swallowed.
                    state_d = redir ? ST_DRAIN : ST_WAIT;
                    tmr_clr = 1'b1;
                end else if (!En) begin
                    state_d = ST_IDLE;
                end else if (redir) begin
                    state_d = ST_FETCH;
                end else if (instr_valid_q && Stall) begin
                    state_d = ST_HOLD;
                end
            end

            ST_HOLD: begin
                cw = CW_HOLD;
                if (!En) begin
                    state_d = ST_IDLE;
                end else if (consume || redir) begin
                    state_d = ST_FETCH;
                end
            end

            ST_WAIT: begin
                cw      = CW_REQ;
                tmr_inc = 1'b1;
                if (IMemRValid) begin
                    // A response coinciding with a redirect belongs to the
                    // squashed path; it is dropped and nothing is left to drain.
                    if (!redir) begin
                        cw            = CW_CAPT;
                        instr_d       = IMemRData;
                        instr_pc_d    = pc_q;
                        instr_valid_d = 1'b1;
                        pc_d          = pc_q + XLEN'(PC_INC);
                    end
                    state_d = ST_FETCH;
                end else if (tmr_expire) begin
                    state_d   = ST_ERR;
                    timeout_d = 1'b1;
                end else if (redir) begin
                    // Timer keeps running: DRAIN waits on the same request.
                    state_d = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                cw      = CW_REQ;
                tmr_inc = 1'b1;
                if (IMemRValid) begin
                    state_d = ST_FETCH;
                end else if (tmr_expire) begin
                    state_d   = ST_ERR;
                    timeout_d = 1'b1;
                end
            end

            ST_ERR: begin
                state_d = ST_ERR;
            end

            default: begin
                state_d = ST_ERR;
            end
        endcase

        // Redirect overrides the PC, flushes the slot even if it was just
        // consumed or refilled, and owns the control word.
        if (redir) begin
            cw            = CW_REDIR;
            pc_d          = RedirectPc;
            instr_valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            timeout_q     <= timeout_d;
        end
    end

    assign IMemReq    = req;
    assign IMemAddr   = pc_q;
    assign Instr      = instr_q;
    assign InstrPc    = instr_pc_q;
    assign InstrValid = instr_valid_q;
    assign CtrlWrd    = cw;
    assign Busy       = (state_q != ST_IDLE) && (state_q != ST_ERR);
    assign Timeout    = timeout_q;

endmodule
`default_nettype wire
